// File: rtl/capture_wr_sched.sv
// capture_wr_sched: write-side scheduler for the bitstream capture path.
//   Allocates 4 KiB-aligned DDR space per capture command, keeps an id->addr/size table,
//   chops each transfer into AXI write burst descriptors and reports completion per command.
// Ports:
//   m_axi_aclk/m_axi_aresetn            clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_id/cmd_size capture command handshake
//   burst_valid/ready/addr/len/last     burst descriptors to the AXI write engine (len = beats-1)
//   b_valid/b_resp                      B responses, always accepted
//   done/done_err/done_id               one-cycle completion pulse per command
//   lkp_id -> lkp_hit/addr/size         registered table lookup for the loader
module capture_wr_sched #(
  parameter int          ADDR_WIDTH    = 34,
  parameter int          ID_WIDTH      = 4,
  parameter int          SIZE_WIDTH    = 32,
  parameter int          BEAT_BYTES    = 64,
  parameter int          MAX_BURST_LEN = 64,
  parameter int          MAX_OUTSTAND  = 8,
  parameter logic [63:0] REGION_BASE   = 64'h0,
  parameter logic [63:0] REGION_SIZE   = 64'h4000_0000
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [SIZE_WIDTH-1:0] cmd_size,
  output logic                  burst_valid,
  input  logic                  burst_ready,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic [7:0]            burst_len,
  output logic                  burst_last,
  input  logic                  b_valid,
  input  logic [1:0]            b_resp,
  output logic                  done,
  output logic                  done_err,
  output logic [ID_WIDTH-1:0]   done_id,
  input  logic [ID_WIDTH-1:0]   lkp_id,
  output logic                  lkp_hit,
  output logic [ADDR_WIDTH-1:0] lkp_addr,
  output logic [SIZE_WIDTH-1:0] lkp_size
);
  localparam int BW = $clog2(BEAT_BYTES);
  localparam int RW = SIZE_WIDTH - BW + 1;
  localparam int OW = $clog2(MAX_OUTSTAND + 1);
  localparam int NS = 2 ** ID_WIDTH;
  localparam logic [ADDR_WIDTH:0] REGION_END = (ADDR_WIDTH+1)'(REGION_BASE + REGION_SIZE);
  localparam logic [RW-1:0] MBL = RW'(MAX_BURST_LEN);
  localparam logic [OW-1:0] MO = OW'(MAX_OUTSTAND);
  typedef enum logic [2:0] {IDLE, ALLOC, ISSUE, WAIT_B, DONE, ERR} state_t;
  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [OW-1:0]         out_q, out_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [NS-1:0]         tbl_valid_q, tbl_valid_d;
  logic [ADDR_WIDTH-1:0] tbl_addr_q [NS];
  logic [ADDR_WIDTH-1:0] tbl_addr_d [NS];
  logic [SIZE_WIDTH-1:0] tbl_size_q [NS];
  logic [SIZE_WIDTH-1:0] tbl_size_d [NS];
  logic                  lkp_hit_q, lkp_hit_d;
  logic [ADDR_WIDTH-1:0] lkp_addr_q, lkp_addr_d;
  logic [SIZE_WIDTH-1:0] lkp_size_q, lkp_size_d;
  logic [RW-1:0]         beats, bnd, cur_a, cur;
  logic [ADDR_WIDTH:0]   alloc_bytes, ptr_end;
  logic                  reuse, ovf, issuing, hs, b_ok, last;
  always_comb begin
    beats       = RW'(({1'b0, size_q} + (SIZE_WIDTH+1)'(BEAT_BYTES - 1)) >> BW);
    // Whole beats rounded up to 4 KiB equals the byte size rounded up to 4 KiB.
    alloc_bytes = (ADDR_WIDTH+1)'(({1'b0, size_q} + (SIZE_WIDTH+1)'(4095)) >> 12) << 12;
    ptr_end     = {1'b0, ptr_q} + alloc_bytes;
    reuse       = tbl_valid_q[id_q] && tbl_size_q[id_q] >= size_q;
    ovf         = ptr_end > REGION_END;
    bnd         = RW'((13'h1000 - {1'b0, addr_q[11:0]}) >> BW);
    cur_a       = rem_q < MBL ? rem_q : MBL;
    cur         = bnd < cur_a ? bnd : cur_a;
    last        = rem_q == cur;
    issuing     = state_q == ISSUE && out_q != MO;
    hs          = issuing && burst_ready;
    b_ok        = b_valid && out_q != '0;
  end
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    size_d      = size_q;
    err_d       = err_q | (b_ok && b_resp != 2'b00);
    addr_d      = addr_q;
    rem_d       = rem_q;
    ptr_d       = ptr_q;
    out_d       = out_q + OW'(hs) - OW'(b_ok);
    tbl_valid_d = tbl_valid_q;
    tbl_addr_d  = tbl_addr_q;
    tbl_size_d  = tbl_size_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        state_d = ALLOC;
        id_d    = cmd_id;
        size_d  = cmd_size;
      end
      ALLOC: begin
        err_d = 1'b0;
        rem_d = beats;
        if (size_q == '0) state_d = DONE;
        else if (reuse) begin
          addr_d             = tbl_addr_q[id_q];
          tbl_size_d[id_q]   = size_q;
          state_d            = ISSUE;
        end else if (ovf) state_d = ERR;
        else begin
          addr_d             = ptr_q;
          ptr_d              = ADDR_WIDTH'(ptr_end);
          tbl_valid_d[id_q]  = 1'b1;
          tbl_addr_d[id_q]   = ptr_q;
          tbl_size_d[id_q]   = size_q;
          state_d            = ISSUE;
        end
      end
      ISSUE: if (hs) begin
        addr_d  = addr_q + (ADDR_WIDTH'(cur) << BW);
        rem_d   = rem_q - cur;
        state_d = last ? WAIT_B : ISSUE;
      end
      WAIT_B: state_d = out_q == '0 ? DONE : WAIT_B;
      DONE: begin
        // A failed capture must not be handed to the loader.
        if (err_q) tbl_valid_d[id_q] = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = state_d == IDLE;
    lkp_hit_d   = tbl_valid_q[lkp_id];
    lkp_addr_d  = tbl_addr_q[lkp_id];
    lkp_size_d  = tbl_size_q[lkp_id];
  end
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= IDLE;
      id_q        <= '0;
      size_q      <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      out_q       <= '0;
      ptr_q       <= ADDR_WIDTH'(REGION_BASE);
      cmd_ready_q <= 1'b0;
      tbl_valid_q <= '0;
      for (int i = 0; i < NS; i++) begin
        tbl_addr_q[i] <= '0;
        tbl_size_q[i] <= '0;
      end
      lkp_hit_q   <= 1'b0;
      lkp_addr_q  <= '0;
      lkp_size_q  <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      size_q      <= size_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      out_q       <= out_d;
      ptr_q       <= ptr_d;
      cmd_ready_q <= cmd_ready_d;
      tbl_valid_q <= tbl_valid_d;
      tbl_addr_q  <= tbl_addr_d;
      tbl_size_q  <= tbl_size_d;
      lkp_hit_q   <= lkp_hit_d;
      lkp_addr_q  <= lkp_addr_d;
      lkp_size_q  <= lkp_size_d;
    end
  end
  assign cmd_ready   = cmd_ready_q;
  assign burst_valid = issuing;
  assign burst_addr  = state_q == ISSUE ? addr_q : '0;
  assign burst_len   = state_q == ISSUE ? 8'(cur - RW'(1)) : '0;
  assign burst_last  = state_q == ISSUE && last;
  assign done        = state_q == DONE || state_q == ERR;
  assign done_err    = state_q == ERR || (state_q == DONE && err_q);
  assign done_id     = done ? id_q : '0;
  assign lkp_hit     = lkp_hit_q;
  assign lkp_addr    = lkp_addr_q;
  assign lkp_size    = lkp_size_q;
endmodule

// File: tb/tb_capture_wr_sched.sv
// tb_capture_wr_sched: scoreboard bench for capture_wr_sched (region 0x4000 bytes, 2 outstanding bursts).
module tb_capture_wr_sched;
  localparam longint REG_END = 64'h4000;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_size;
  logic        burst_valid, burst_ready, burst_last;
  logic [33:0] burst_addr;
  logic [7:0]  burst_len;
  logic        b_valid;
  logic [1:0]  b_resp;
  logic        done, done_err;
  logic [3:0]  done_id;
  logic [3:0]  lkp_id;
  logic        lkp_hit;
  logic [33:0] lkp_addr;
  logic [31:0] lkp_size;
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int b_cnt = 0;
  int err_at = -1;
  bit b_auto = 1'b1;
  logic [42:0] exp_b [$];
  logic [4:0]  exp_d [$];
  logic [42:0] eb;
  logic [4:0]  ed;
  bit          m_valid [16];
  longint      m_addr [16];
  longint      m_size [16];
  longint      m_ptr;
  capture_wr_sched #(.REGION_SIZE(64'h4000), .MAX_OUTSTAND(2)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_size(cmd_size),
    .burst_valid(burst_valid), .burst_ready(burst_ready), .burst_addr(burst_addr),
    .burst_len(burst_len), .burst_last(burst_last),
    .b_valid(b_valid), .b_resp(b_resp),
    .done(done), .done_err(done_err), .done_id(done_id),
    .lkp_id(lkp_id), .lkp_hit(lkp_hit), .lkp_addr(lkp_addr), .lkp_size(lkp_size)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (burst_valid && burst_ready) begin
      if (exp_b.size() == 0) chk("burst_unexpected", 1, 0);
      else begin
        eb = exp_b.pop_front();
        chk("burst", {burst_addr, burst_len, burst_last}, eb);
      end
      hs_cnt++;
    end
    if (done) begin
      if (exp_d.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        ed = exp_d.pop_front();
        chk("done", {done_err, done_id}, ed);
      end
      done_cnt++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (b_auto && hs_cnt > b_cnt) begin
      b_valid = 1'b1;
      b_resp  = b_cnt == err_at ? 2'b10 : 2'b00;
      b_cnt++;
    end else begin
      b_valid = 1'b0;
      b_resp  = 2'b00;
    end
  endtask
  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask
  task automatic expect_cmd(input int id, input longint size, input bit berr);
    longint base, ab, a, bt, n;
    if (size == 0) begin
      exp_d.push_back({1'b0, 4'(id)});
      return;
    end
    if (m_valid[id] && m_size[id] >= size) begin
      base = m_addr[id];
      m_size[id] = size;
    end else begin
      ab = ((size + 4095) / 4096) * 4096;
      if (m_ptr + ab > REG_END) begin
        exp_d.push_back({1'b1, 4'(id)});
        return;
      end
      base = m_ptr;
      m_ptr += ab;
      m_valid[id] = 1'b1;
      m_addr[id] = base;
      m_size[id] = size;
    end
    a = base;
    bt = (size + 63) / 64;
    while (bt > 0) begin
      n = bt < 64 ? bt : 64;
      if ((4096 - a % 4096) / 64 < n) n = (4096 - a % 4096) / 64;
      exp_b.push_back({a[33:0], 8'(n - 1), bt == n});
      a += n * 64;
      bt -= n;
    end
    exp_d.push_back({berr, 4'(id)});
    if (berr) m_valid[id] = 1'b0;
  endtask
  task automatic send(input int id, input longint size);
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_id    = 4'(id);
    cmd_size  = 32'(size);
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int i = 0; i < 300 && done_cnt == start; i++) tick();
    chk("done_seen", done_cnt > start, 1);
    tick();
  endtask
  task automatic lookup(input int id, input bit hit, input longint addr, input longint size);
    lkp_id = 4'(id);
    tick();
    chk("lkp_hit", lkp_hit, hit);
    if (hit) begin
      chk("lkp_addr", lkp_addr, addr);
      chk("lkp_size", lkp_size, size);
    end
  endtask
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_size = '0; burst_ready = 1'b1;
    b_valid = 1'b0; b_resp = 2'b00; lkp_id = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_outputs", {cmd_ready, burst_valid, done, done_err, lkp_hit}, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    expect_cmd(3, 10000, 0);
    send(3, 10000);
    wait_done();
    lookup(3, 1, 0, 10000);
    expect_cmd(3, 5000, 0);
    send(3, 5000);
    wait_done();
    lookup(3, 1, 0, 5000);
    expect_cmd(5, 8192, 0);
    send(5, 8192);
    wait_done();
    lookup(5, 0, 0, 0);
    expect_cmd(1, 64, 0);
    send(1, 64);
    lkp_id = 4'd1;
    tick();
    chk("lkp_same_cycle_old", lkp_hit, 0);
    wait_done();
    lookup(1, 1, 'h3000, 64);
    err_at = b_cnt + 1;
    expect_cmd(3, 5000, 1);
    send(3, 5000);
    wait_done();
    err_at = -1;
    lookup(3, 0, 0, 0);
    expect_cmd(2, 0, 0);
    send(2, 0);
    wait_done();
    lookup(2, 0, 0, 0);
    lookup(1, 1, 'h3000, 64);
    burst_ready = 1'b0;
    send(1, 64);
    repeat (2) tick();
    chk("issue_desc", {burst_valid, burst_addr, burst_len, burst_last}, {1'b1, 34'h3000, 8'd0, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {cmd_ready, burst_valid, burst_addr, burst_len, burst_last, done, done_err, done_id, lkp_hit}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
    burst_ready = 1'b1;
    b_cnt = hs_cnt;
    repeat (3) tick();
    lookup(1, 0, 0, 0);
    b_auto = 1'b0;
    burst_ready = 1'b0;
    expect_cmd(7, 16384, 0);
    send(7, 16384);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("hold_desc", {burst_valid, burst_addr, burst_len}, {1'b1, 34'h0, 8'd63});
      tick();
    end
    burst_ready = 1'b1;
    tick();
    tick();
    chk("blocked_at_max", burst_valid, 0);
    tick();
    chk("blocked_at_max", burst_valid, 0);
    b_valid = 1'b1;
    tick();
    chk("unblocked", {burst_valid, burst_addr}, {1'b1, 34'h2000});
    b_valid = 1'b1;
    tick();
    chk("coincident_b", {burst_valid, burst_addr}, {1'b1, 34'h3000});
    tick();
    burst_ready = 1'b0;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b1;
    tick();
    wait_done();
    b_auto = 1'b1;
    b_cnt = hs_cnt;
    burst_ready = 1'b1;
    lookup(7, 1, 0, 16384);
    repeat (3) tick();
    chk("bursts_left", exp_b.size(), 0);
    chk("dones_left", exp_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
